id_fetch_ctrl: RTL and testbench

- Consumer end of the fetch interface: registers the IF stage's address/instruction pair (IF/ID pipeline register).
- Resolves JAL/JALR/conditional branches held in that register and drives the redirect pair (select, branch address) back into the IF stage's next-PC mux.
- Squashes the wrong-path instruction and provides a PC-hold for stalls.

---
 rtl/id_fetch_ctrl_pkg.sv | 26 ++
 rtl/id_branch_resolve.sv | 55 +++++
 rtl/id_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_id_fetch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_fetch_ctrl_pkg.sv
// Shared constants for the IF/ID control slice: RV32 control-flow opcodes,
// branch funct3 codes, the bubble instruction and the decode-slot state encoding.
// Imported by id_fetch_ctrl and id_branch_resolve.
package id_fetch_ctrl_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BUBBLE = 2'd0,   // slot empty after reset
        S_RUN    = 2'd1,   // slot holds a live instruction
        S_KILL   = 2'd2    // slot holds a squashed wrong-path fetch
    } state_t;

endpackage

// File: rtl/id_branch_resolve.sv
// Control-flow resolver for the decode slot: decodes JAL/JALR/Bxx, compares
// operands and forms the target address. Purely combinational (0 cycles).
// Ports: instr/pc/rs1/rs2 in; take (redirect wanted) and target out.
module id_branch_resolve
    import id_fetch_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        take,
    output logic [31:0] target
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        take   = 1'b0;
        target = 32'h0;
        case (opcode)
            OP_JAL: begin
                take   = 1'b1;
                target = pc + imm_j;
            end
            OP_JALR: begin
                take   = 1'b1;
                target = (rs1 + imm_i) & ~32'h1;
            end
            OP_BRANCH: begin
                target = pc + imm_b;
                case (funct3)
                    F3_BEQ:  take = (rs1 == rs2);
                    F3_BNE:  take = (rs1 != rs2);
                    F3_BLT:  take = ($signed(rs1) <  $signed(rs2));
                    F3_BGE:  take = ($signed(rs1) >= $signed(rs2));
                    F3_BLTU: take = (rs1 <  rs2);
                    F3_BGEU: take = (rs1 >= rs2);
                    default: take = 1'b0;   // funct3 010/011 are not branches
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_fetch_ctrl.sv
// IF/ID pipeline register with branch/jump resolution and redirect to IF next-PC mux.
// Latency: slot registers 1 cycle; redirect combinational from slot, 1-cycle penalty.
// Backpressure: i_stall holds slot, state and counter; o_pc_hold mirrors it to IF.
// Ports: fetch pair in, rs1/rs2 operands in, slot pc/instr/valid out, select/target out.
// Optional macro ID_REDIRECT_CNT_EN adds a taken-redirect counter on o_redirect_cnt.
module id_fetch_ctrl
    import id_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_address,
    input  logic [31:0]      i_instruccion,
    input  logic             i_stall,
    input  logic [31:0]      i_rs1_data,
    input  logic [31:0]      i_rs2_data,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_instruccion,
    output logic             o_valid,
    output logic [31:0]      o_branch_address,
    output logic             o_select,
    output logic             o_pc_hold,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic        take;
    logic [31:0] target;
    logic        redirect;

    id_branch_resolve u_resolve (
        .instr  (instr_q),
        .pc     (pc_q),
        .rs1    (i_rs1_data),
        .rs2    (i_rs2_data),
        .take   (take),
        .target (target)
    );

    // Only a live, unstalled slot may steer IF; killed/bubble slots never do,
    // which rules out back-to-back redirects. Reset masks it so IF sees a
    // clean select while the pipe is being flushed.
    assign redirect = !i_reset && (state_q == S_RUN) && !i_stall && take;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_BUBBLE;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        instr_n = instr_q;
        if (!i_stall) begin
            pc_n = i_address;
            if (redirect) begin
                // The fetch in flight is on the wrong path: keep its PC but squash it.
                instr_n = NOP_INSTR;
                state_n = S_KILL;
            end else begin
                instr_n = i_instruccion;
                state_n = S_RUN;
            end
        end
    end

    assign o_pc             = pc_q;
    assign o_instruccion    = instr_q;
    assign o_valid          = (state_q == S_RUN);
    assign o_select         = redirect;
    assign o_branch_address = redirect ? target : 32'h0;
    assign o_pc_hold        = i_stall;

`ifdef ID_REDIRECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // redirect already excludes stalled cycles, so the count holds on stall.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (redirect) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_redirect_cnt = cnt_q;
`else
    assign o_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_id_fetch_ctrl.sv
module tb_id_fetch_ctrl;

    localparam int CNT_W = 16;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BEQ  = 32'h0020_8463;
    localparam logic [31:0] BNE  = 32'h0020_9463;
    localparam logic [31:0] JALR = 32'h0000_80E7;
    localparam logic [31:0] JAL  = 32'h0100_006F;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      addr;
    logic [31:0]      ins;
    logic             stall;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      o_pc;
    logic [31:0]      o_ins;
    logic             o_valid;
    logic [31:0]      o_baddr;
    logic             o_sel;
    logic             o_hold;
    logic [CNT_W-1:0] o_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference slot: what the decode register must contain, by the rules.
    logic [31:0]      m_pc;
    logic [31:0]      m_ins;
    bit               m_val;
    logic [CNT_W-1:0] m_cnt;
    bit               mdl_on = 0;

    always #5 clk = ~clk;

    id_fetch_ctrl #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_address        (addr),
        .i_instruccion    (ins),
        .i_stall          (stall),
        .i_rs1_data       (rs1),
        .i_rs2_data       (rs2),
        .o_pc             (o_pc),
        .o_instruccion    (o_ins),
        .o_valid          (o_valid),
        .o_branch_address (o_baddr),
        .o_select         (o_sel),
        .o_pc_hold        (o_hold),
        .o_redirect_cnt   (o_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Decide from the instruction word whether control flow leaves the
    // sequential path, using field arithmetic with signed bit weights.
    function automatic bit m_resolve(input logic [31:0] w, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] tgt);
        logic [31:0] op, f3, ii, bi, ji, s;
        bit t;
        op = w & 32'h7f;
        f3 = (w >> 12) & 32'h7;
        ii = w >> 20;
        if (w[31]) ii = ii - 32'h1000;
        bi = (((w >> 8) & 32'hf) << 1) + (((w >> 25) & 32'h3f) << 5) + (((w >> 7) & 32'h1) << 11);
        if (w[31]) bi = bi - 32'h1000;
        ji = (((w >> 21) & 32'h3ff) << 1) + (((w >> 20) & 32'h1) << 11) + (((w >> 12) & 32'hff) << 12);
        if (w[31]) ji = ji - 32'h10_0000;
        t = 0;
        tgt = 32'h0;
        if (op == 32'h6f) begin
            t = 1; tgt = pc + ji;
        end else if (op == 32'h67) begin
            s = a + ii;
            t = 1; tgt = s - (s % 2);
        end else if (op == 32'h63) begin
            case (f3)
                0: t = (a == b);
                1: t = (a != b);
                4: t = ($signed(a) <  $signed(b));
                5: t = ($signed(a) >= $signed(b));
                6: t = (a <  b);
                7: t = (a >= b);
                default: t = 0;
            endcase
            tgt = pc + bi;
        end
        return t;
    endfunction

    function automatic bit m_select();
        logic [31:0] tg;
        return !rst && m_val && !stall && m_resolve(m_ins, m_pc, rs1, rs2, tg);
    endfunction

    task automatic model_update();
        if (rst) begin
            m_pc = 0; m_ins = NOP; m_val = 0; m_cnt = '0;
        end else if (!stall) begin
            if (m_select()) begin
                m_pc = addr; m_ins = NOP; m_val = 0;
`ifdef ID_REDIRECT_CNT_EN
                m_cnt = m_cnt + 1'b1;
`endif
            end else begin
                m_pc = addr; m_ins = ins; m_val = 1;
            end
        end
    endtask

    task automatic model_compare();
        logic [31:0] tg;
        bit sel;
        sel = m_select();
        void'(m_resolve(m_ins, m_pc, rs1, rs2, tg));
        chk("pc",     o_pc,  m_pc);
        chk("instr",  o_ins, m_ins);
        chk("valid",  {31'b0, o_valid}, {31'b0, m_val});
        chk("select", {31'b0, o_sel},   {31'b0, sel});
        chk("baddr",  o_baddr, sel ? tg : 32'h0);
        chk("hold",   {31'b0, o_hold},  {31'b0, stall});
        chk("cnt",    32'(o_cnt), 32'(m_cnt));
    endtask

    // Sample mid-cycle, after inputs for this cycle are applied.
    task automatic tick();
        @(negedge clk);
        if (mdl_on) model_compare();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [31:0] pick_rs();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h5;
            2: return 32'hffff_ffff;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1: return {r[31:7], 7'b1100011};
            2:    return {r[31:7], 7'b1101111};
            3:    return {r[31:7], 7'b1100111};
            default: return r;
        endcase
    endfunction

    logic [31:0] cnt_mid;
    logic [31:0] cnt_end;

    initial begin
`ifdef ID_REDIRECT_CNT_EN
        cnt_mid = 32'd3;
        cnt_end = 32'd4;
`else
        cnt_mid = 32'd0;
        cnt_end = 32'd0;
`endif
        rst = 1; stall = 0; addr = 0; ins = ADDI; rs1 = 0; rs2 = 0;

        // Reset held two edges.
        step();
        mdl_on = 1;
        tick();
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_instr", o_ins, 32'h13);
        chk("rst_select", {31'b0, o_sel}, 32'd0);
        step();
        tick();
        rst = 0;
        step();
        tick();
        chk("rel_pc", o_pc, 32'h0);
        chk("rel_valid", {31'b0, o_valid}, 32'd1);
        chk("rel_select", {31'b0, o_sel}, 32'd0);

        // BEQ taken at 0x10.
        addr = 32'h10; ins = BEQ;
        step();
        rs1 = 5; rs2 = 5; addr = 32'h14; ins = ADDI;
        tick();
        chk("beq_select", {31'b0, o_sel}, 32'd1);
        chk("beq_target", o_baddr, 32'h18);
        step();
        addr = 32'h18; ins = ADDI;
        tick();
        chk("beq_kill_valid", {31'b0, o_valid}, 32'd0);
        chk("beq_kill_instr", o_ins, 32'h13);
        step();
        tick();
        chk("beq_tgt_pc", o_pc, 32'h18);

        // BNE not taken.
        addr = 32'h10; ins = BNE;
        step();
        addr = 32'h14; ins = ADDI;
        tick();
        chk("bne_select", {31'b0, o_sel}, 32'd0);
        chk("bne_baddr", o_baddr, 32'h0);
        step();
        tick();
        chk("bne_pc", o_pc, 32'h14);
        chk("bne_valid", {31'b0, o_valid}, 32'd1);

        // JALR then JAL.
        addr = 32'h40; ins = JALR;
        step();
        rs1 = 32'h103; addr = 32'h44; ins = ADDI;
        tick();
        chk("jalr_target", o_baddr, 32'h102);
        step();
        addr = 32'h20; ins = JAL;
        tick();
        step();
        addr = 32'h24; ins = ADDI;
        tick();
        chk("jal_target", o_baddr, 32'h30);
        step();

        // Taken BEQ under a 3-cycle stall.
        addr = 32'h10; ins = BEQ; rs1 = 5; rs2 = 5;
        tick();
        step();
        stall = 1; addr = 32'h14; ins = ADDI;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_select", {31'b0, o_sel}, 32'd0);
            chk("stl_hold", {31'b0, o_hold}, 32'd1);
            chk("stl_pc", o_pc, 32'h10);
            chk("stl_instr", o_ins, BEQ);
            chk("stl_cnt", 32'(o_cnt), cnt_mid);
            step();
        end
        stall = 0;
        tick();
        chk("unstl_select", {31'b0, o_sel}, 32'd1);
        step();
        tick();
        chk("unstl_cnt", 32'(o_cnt), cnt_end);

        // Reset in the kill cycle while stalled.
        rst = 1; stall = 1;
        step();
        tick();
        chk("krst_pc", o_pc, 32'h0);
        chk("krst_instr", o_ins, 32'h13);
        chk("krst_valid", {31'b0, o_valid}, 32'd0);
        chk("krst_select", {31'b0, o_sel}, 32'd0);
        chk("krst_baddr", o_baddr, 32'h0);
        chk("krst_cnt", 32'(o_cnt), 32'd0);
        rst = 0; stall = 0;
        step();

        // Randomized traffic against the reference slot.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 4) == 0);
            addr  = $urandom & 32'hffff_fffc;
            ins   = pick_ins();
            rs1   = pick_rs();
            rs2   = ($urandom_range(0, 2) == 0) ? rs1 : pick_rs();
            tick();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
